// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream in, program memory write bus out, for instruction_loader
interface instruction_loader_if #(
  parameter int NB_DATA  = 8,
  parameter int NB_INSTR = 16,
  parameter int NB_ADDR  = 11
);
  logic                i_start;
  logic [NB_DATA-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                o_rx_ready;
  logic                o_wr_en;
  logic [NB_ADDR-1:0]  o_wr_addr;
  logic [NB_INSTR-1:0] o_wr_data;
  logic [NB_ADDR:0]    o_count;
  logic                o_load_done;
  logic                o_error;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_rx_ready, o_wr_en, o_wr_addr, o_wr_data, o_count, o_load_done, o_error
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_rx_ready, o_wr_en, o_wr_addr, o_wr_data, o_count, o_load_done, o_error
  );
endinterface

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - assembles byte pairs into instructions and writes legal ones to program memory
// Optional trailing XOR checksum byte after HLT: LOADER_CHECKSUM_EN
module instruction_loader #(
  parameter int NB_DATA   = 8,
  parameter int NB_INSTR  = 16,
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = 11,
  parameter int MEM_DEPTH = 2048
) (
  input logic            i_clock,
  input logic            i_reset,
  instruction_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, HIGH, LOW, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t               state, state_next;
  logic [NB_DATA-1:0]   hi_byte;
  logic [NB_ADDR-1:0]   ptr;
  logic [NB_ADDR:0]     count;
  logic                 rx_ready;
  logic                 wr_en;
  logic [NB_ADDR-1:0]   wr_addr;
  logic [NB_INSTR-1:0]  wr_data;
  logic                 load_done;
  logic                 error;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_DATA-1:0]   csum;
`endif

  logic                 xfer;
  logic [NB_OPCODE-1:0] opcode;
  logic                 legal;
  logic                 hlt;
  logic                 last_addr;
  logic [NB_INSTR-1:0]  word;

  assign xfer      = bus.i_rx_valid && rx_ready;
  assign opcode    = hi_byte[NB_DATA-1 -: NB_OPCODE];
  assign legal     = (opcode <= NB_OPCODE'(7));
  assign hlt       = (opcode == '0);
  assign last_addr = (ptr == NB_ADDR'(MEM_DEPTH - 1));
  assign word      = {hi_byte, bus.i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (bus.i_start) state_next = HIGH;
      HIGH:              if (xfer) state_next = LOW;
      LOW:               if (xfer) state_next = WRITE;
      WRITE: begin
        if (!legal)         state_next = ERROR;
`ifdef LOADER_CHECKSUM_EN
        else if (hlt)       state_next = CHECK;
`else
        else if (hlt)       state_next = DONE;
`endif
        else if (last_addr) state_next = ERROR;
        else                state_next = HIGH;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_next = (bus.i_rx_data == csum) ? DONE : ERROR;
`endif
      default:           state_next = IDLE;
    endcase
  end

  // Status and ready are registered copies of the next state, so they line up with the state itself.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hi_byte   <= '0;
      ptr       <= '0;
      count     <= '0;
      rx_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      rx_ready  <= (state_next == HIGH) || (state_next == LOW)
`ifdef LOADER_CHECKSUM_EN
                   || (state_next == CHECK)
`endif
                   ;
      load_done <= (state_next == DONE);
      error     <= (state_next == ERROR);
      wr_en     <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (bus.i_start) begin
          ptr   <= '0;
          count <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum  <= '0;
`endif
        end
        HIGH: if (xfer) begin
          hi_byte <= bus.i_rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum    <= csum ^ bus.i_rx_data;
`endif
        end
        LOW: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ bus.i_rx_data;
`endif
          // Address/data only move for a legal word so they hold through illegal ones.
          if (legal) begin
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= word;
          end
        end
        WRITE: if (legal) begin
          count <= count + 1'b1;
          if (!hlt && !last_addr) ptr <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rx_ready  = rx_ready;
  assign bus.o_wr_en     = wr_en;
  assign bus.o_wr_addr   = wr_addr;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_count     = count;
  assign bus.o_load_done = load_done;
  assign bus.o_error     = error;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the program-memory/decoder interface. Receives a byte stream (e.g. from UART RX) over a valid/ready handshake and assembles 16-bit instructions: opcode in [15:11], operand in [10:0]. Validates each opcode against the CPU instruction set, writes legal instructions into program memory at consecutive addresses, and stops on HLT. Sits between the serial receiver and program memory, ahead of the CPU that decodes the stored opcodes.

Parameters:
NB_DATA, 8, byte width of input stream
NB_INSTR, 16, instruction width
NB_OPCODE, 5, opcode field width (bits [15:11])
NB_ADDR, 11, program memory address width
MEM_DEPTH, 2048, number of program memory words

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  begin (or restart) a program load
i_rx_data  input  NB_DATA  incoming byte
i_rx_valid  input  1  i_rx_data valid
o_rx_ready  output  1  loader can accept a byte
o_wr_en  output  1  program memory write strobe, one cycle
o_wr_addr  output  NB_ADDR  program memory write address
o_wr_data  output  NB_INSTR  instruction word to write
o_count  output  NB_ADDR+1  instructions written in current load
o_load_done  output  1  load finished with HLT; held
o_error  output  1  illegal opcode or memory overflow; held

Behaviour:
- Reset: state IDLE; o_rx_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_count=0, o_load_done=0, o_error=0; partial byte discarded. Reset mid-load has the same effect; nothing further is written.
- Byte transfer occurs only on a cycle with i_rx_valid=1 and o_rx_ready=1. o_rx_ready is a registered function of state and does not depend combinationally on i_rx_valid.
- States:
  - IDLE: ready=0. i_start -> HIGH; address pointer=0, o_count=0, done/error cleared.
  - HIGH: ready=1. On transfer, latch byte as instr[15:8] -> LOW.
  - LOW: ready=1. On transfer, latch byte as instr[7:0] -> WRITE.
  - WRITE: ready=0. Opcode check on instr[15:11]; legal set 5'b00000..5'b00111 (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI).
    - Illegal: no write; -> ERROR.
    - Legal: o_wr_en=1 this cycle, o_wr_addr=pointer, o_wr_data=instr; o_count increments on the following edge.
    - Legal and HLT: -> DONE.
    - Legal, non-HLT, pointer==MEM_DEPTH-1: word is written, then -> ERROR (overflow, no HLT).
    - Otherwise: pointer+1 -> HIGH.
  - DONE: o_load_done=1 held, ready=0. i_start -> HIGH, restarting at address 0 with counters cleared.
  - ERROR: o_error=1 held, ready=0. i_start -> HIGH as in DONE.
- i_start is ignored in HIGH, LOW and WRITE.
- Throughput: one instruction per 2 accepted bytes plus one WRITE cycle. Minimum 3 cycles per instruction.
- Latency: o_wr_en asserts exactly 1 cycle after the low-byte transfer.
- o_wr_addr/o_wr_data hold their last values when o_wr_en=0.
- Pointer never wraps; overflow is always reported via ERROR.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the HLT write, FSM enters CHECK (ready=1) and accepts one extra byte. The byte must equal the XOR of all instruction bytes received in this load, including the HLT bytes. Match -> DONE; mismatch -> ERROR. The running XOR clears on i_start and on reset.
- Not defined: no CHECK state; HLT write goes directly to DONE.

Test Plan:
- Reset, i_start; bytes 0x18,0x05 (LDI 5), 0x28,0x03 (ADDI 3), 0x00,0x00 (HLT) -> writes addr0=0x1805, addr1=0x2803, addr2=0x0000; o_count=3; o_load_done=1; o_error=0.
- Bytes 0x40,0x01 (opcode 01000) after i_start -> no o_wr_en; o_error=1; o_count=0; a new i_start clears o_error and re-accepts from addr0.
- i_rx_valid toggling 1/0 every cycle during the LDI/ADDI/HLT program -> same memory contents; o_wr_en pulses exactly 3 times, each 1 cycle wide, each 1 cycle after its low-byte transfer.
- i_reset asserted after only the high byte 0x18 -> no write; all outputs 0; next load begins with the high byte at addr0.
- MEM_DEPTH=4, four 0x08,0x00 (STO 0) words -> addrs 0-3 written; o_error=1 after the 4th write; o_count=4.
- LOADER_CHECKSUM_EN defined, program 0x18,0x05,0x00,0x00 then checksum 0x1D -> o_load_done=1. Same program with 0x1C -> o_error=1.
